// File: rtl/rom_loader_cram.sv
// rom_loader_cram: buffers 32-bit big-endian bridge ROM writes in a FIFO and drains them to CRAM
// as two 16-bit word writes over a req/ack handshake. Define ROM_LOADER_CHECKSUM_EN to add rom_checksum.
module rom_loader_cram #(
    parameter int unsigned FIFO_DEPTH      = 8,
    parameter int unsigned CRAM_ADDR_WIDTH = 22,
    parameter logic [31:0] ROM_BYTES       = 32'h0010_0000
) (
    input  logic                       clk_74a,
    input  logic                       reset_n,
    input  logic                       bridge_wr,
    input  logic [31:0]                bridge_addr,
    input  logic [31:0]                bridge_wr_data,
    output logic                       cram_req,
    output logic [CRAM_ADDR_WIDTH-1:0] cram_addr,
    output logic [15:0]                cram_wdata,
    input  logic                       cram_ack,
    output logic                       busy,
    output logic                       overflow,
    output logic [31:0]                words_written
`ifdef ROM_LOADER_CHECKSUM_EN
    ,
    output logic [31:0]                rom_checksum
`endif
);

    localparam int unsigned AW    = CRAM_ADDR_WIDTH;
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WR_HI = 2'd1,
        WR_LO = 2'd2
    } state_t;

    // Reset asserts asynchronously and releases two edges later, in step with clk_74a.
    logic [1:0] rst_sync_q;
    logic       rst_n_int;

    // NOTE: sequential state always uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_74a or negedge reset_n) begin
        if (!reset_n) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_n_int = rst_sync_q[1];

    logic [AW-1:0]    fifo_addr_q [FIFO_DEPTH];
    logic [31:0]      fifo_data_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             overflow_q;
    logic             busy_q;

    state_t           state_q;
    logic             cram_req_q;
    logic [AW-1:0]    cram_addr_q;
    logic [15:0]      cram_wdata_q;
    logic [15:0]      hold_lo_q;
    logic [31:0]      words_q;

    logic             fifo_empty;
    logic             fifo_full;
    logic             in_range;
    logic             ack_v;
    logic             pop;
    logic             push;
    logic             drop;
    logic             fsm_busy_d;
    logic [AW-1:0]    push_addr;
    logic [AW-1:0]    head_addr;
    logic [31:0]      head_data;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
    assign in_range   = bridge_wr && (bridge_addr <= ROM_BYTES);
    assign ack_v      = cram_ack && cram_req_q;

    // The FSM takes a new word when idle, or straight after the low-half ack to stay back-to-back.
    assign pop  = !fifo_empty && ((state_q == IDLE) || ((state_q == WR_LO) && ack_v));
    assign push = in_range && (!fifo_full || pop);
    assign drop = in_range && fifo_full && !pop;

    assign push_addr = {bridge_addr[AW:2], 1'b0};
    assign head_addr = fifo_addr_q[rd_ptr_q];
    assign head_data = fifo_data_q[rd_ptr_q];

    assign count_d    = count_q + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};
    assign fsm_busy_d = pop || (state_q == WR_HI) || ((state_q == WR_LO) && !ack_v);

    // NOTE: the storage array has no reset; count_q alone says which entries are valid.
    always_ff @(posedge clk_74a) begin
        if (push) begin
            fifo_addr_q[wr_ptr_q] <= push_addr;
            fifo_data_q[wr_ptr_q] <= bridge_wr_data;
        end
    end

    always_ff @(posedge clk_74a or negedge rst_n_int) begin
        if (!rst_n_int) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_d;
            if (drop) begin
                overflow_q <= 1'b1;
            end
            busy_q <= (count_d != '0) || fsm_busy_d;
        end
    end

`ifdef ROM_LOADER_CHECKSUM_EN
    logic [15:0] hold_hi_q;
    logic [31:0] checksum_q;
`endif

    always_ff @(posedge clk_74a or negedge rst_n_int) begin
        if (!rst_n_int) begin
            state_q      <= IDLE;
            cram_req_q   <= 1'b0;
            cram_addr_q  <= '0;
            cram_wdata_q <= '0;
            hold_lo_q    <= '0;
            words_q      <= '0;
`ifdef ROM_LOADER_CHECKSUM_EN
            hold_hi_q    <= '0;
            checksum_q   <= '0;
`endif
        end else begin
            if ((state_q == WR_LO) && ack_v) begin
                words_q <= words_q + 32'd1;
`ifdef ROM_LOADER_CHECKSUM_EN
                checksum_q <= checksum_q + {hold_hi_q, hold_lo_q};
`endif
            end

            if (pop) begin
                state_q      <= WR_HI;
                cram_req_q   <= 1'b1;
                cram_addr_q  <= head_addr;
                cram_wdata_q <= head_data[31:16];
                hold_lo_q    <= head_data[15:0];
`ifdef ROM_LOADER_CHECKSUM_EN
                hold_hi_q    <= head_data[31:16];
`endif
            end else begin
                case (state_q)
                    IDLE: begin
                        cram_req_q <= 1'b0;
                    end
                    WR_HI: begin
                        if (ack_v) begin
                            state_q      <= WR_LO;
                            cram_addr_q  <= cram_addr_q + AW'(1);
                            cram_wdata_q <= hold_lo_q;
                        end
                    end
                    WR_LO: begin
                        if (ack_v) begin
                            state_q    <= IDLE;
                            cram_req_q <= 1'b0;
                        end
                    end
                    default: begin
                        state_q    <= IDLE;
                        cram_req_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign cram_req      = cram_req_q;
    assign cram_addr     = cram_addr_q;
    assign cram_wdata    = cram_wdata_q;
    assign busy          = busy_q;
    assign overflow      = overflow_q;
    assign words_written = words_q;
`ifdef ROM_LOADER_CHECKSUM_EN
    assign rom_checksum  = checksum_q;
`endif

endmodule
